// File: rtl/dmem_response_router.sv
// Return path for the dual-port data memory: grants/stalls each core, advances the
// round-robin pointer, and routes fixed-latency read data / write acks to the issuer.
module dmem_response_router #(
    parameter  int NCORES     = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int LATENCY    = 1,
    localparam int SEL_W      = $clog2(NCORES)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NCORES-1:0]            req_valid_i,
    input  logic [NCORES-1:0]            req_we_i,
    input  logic                         valid_a_i,
    input  logic                         valid_b_i,
    input  logic [SEL_W-1:0]             selector_a_i,
    input  logic [SEL_W-1:0]             selector_b_i,
    output logic [SEL_W-1:0]             rr_ptr_o,
    input  logic [DATA_WIDTH-1:0]        mem_rdata_a_i,
    input  logic [DATA_WIDTH-1:0]        mem_rdata_b_i,
    output logic [NCORES-1:0]            grant_o,
    output logic [NCORES-1:0]            stall_o,
    output logic [NCORES-1:0]            rsp_valid_o,
    output logic [NCORES*DATA_WIDTH-1:0] rsp_rdata_packed_o,
    output logic                         err_o
);

    localparam logic [SEL_W:0] NCORES_W = (SEL_W + 1)'(NCORES);
    localparam logic [SEL_W:0] LAST_W   = (SEL_W + 1)'(NCORES - 1);

    logic [SEL_W-1:0]                   rr_ptr_q, rr_ptr_d;
    logic                               err_q, err_d;
    logic [LATENCY-1:0]                 va_q, va_d, wa_q, wa_d, vb_q, vb_d, wb_q, wb_d;
    logic [LATENCY-1:0][SEL_W-1:0]      sa_q, sa_d, sb_q, sb_d;
    logic [NCORES-1:0]                  rsp_valid_q, rsp_valid_d;
    logic [NCORES*DATA_WIDTH-1:0]       rsp_rdata_q, rsp_rdata_d;

    logic [NCORES-1:0] hit_a, hit_b;
    logic              cap_va, cap_vb, cap_wa, cap_wb, collide, bad_sel;

    // Explicit compare so non-power-of-two core counts wrap correctly.
    function automatic logic [SEL_W-1:0] ptr_inc(input logic [SEL_W-1:0] sel);
        if ({1'b0, sel} >= LAST_W) return '0;
        return sel + SEL_W'(1);
    endfunction

    // Out-of-range selectors never match a core, so their grant is suppressed for free.
    always_comb begin
        hit_a = '0;
        hit_b = '0;
        for (int i = 0; i < NCORES; i++) begin
            hit_a[i] = valid_a_i && (selector_a_i == SEL_W'(i));
            hit_b[i] = valid_b_i && (selector_b_i == SEL_W'(i));
        end
        grant_o = (hit_a | hit_b) & req_valid_i;
        stall_o = req_valid_i & ~grant_o;
        cap_va  = |(hit_a & req_valid_i);
        cap_vb  = |(hit_b & req_valid_i);
        cap_wa  = |(hit_a & req_we_i);
        cap_wb  = |(hit_b & req_we_i);
        collide = cap_va && cap_vb && (selector_a_i == selector_b_i);
        bad_sel = (valid_a_i && ({1'b0, selector_a_i} >= NCORES_W)) ||
                  (valid_b_i && ({1'b0, selector_b_i} >= NCORES_W));
        err_d   = err_q | collide | bad_sel;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (valid_b_i)      rr_ptr_d = ptr_inc(selector_b_i);
        else if (valid_a_i) rr_ptr_d = ptr_inc(selector_a_i);
    end

    // Issue pipeline; on a same-core collision port B's entry is dropped at capture.
    always_comb begin
        va_d = '0; wa_d = '0; vb_d = '0; wb_d = '0; sa_d = '0; sb_d = '0;
        va_d[0] = cap_va;
        wa_d[0] = cap_wa;
        sa_d[0] = selector_a_i;
        vb_d[0] = cap_vb && !collide;
        wb_d[0] = cap_wb;
        sb_d[0] = selector_b_i;
        for (int k = 1; k < LATENCY; k++) begin
            va_d[k] = va_q[k-1];
            wa_d[k] = wa_q[k-1];
            sa_d[k] = sa_q[k-1];
            vb_d[k] = vb_q[k-1];
            wb_d[k] = wb_q[k-1];
            sb_d[k] = sb_q[k-1];
        end
    end

    always_comb begin
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        for (int i = 0; i < NCORES; i++) begin
            if (va_q[LATENCY-1] && (sa_q[LATENCY-1] == SEL_W'(i))) begin
                rsp_valid_d[i] = 1'b1;
                if (!wa_q[LATENCY-1]) rsp_rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_rdata_a_i;
            end
            if (vb_q[LATENCY-1] && (sb_q[LATENCY-1] == SEL_W'(i))) begin
                rsp_valid_d[i] = 1'b1;
                if (!wb_q[LATENCY-1]) rsp_rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_rdata_b_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= '0;
            err_q       <= 1'b0;
            va_q        <= '0;
            wa_q        <= '0;
            sa_q        <= '0;
            vb_q        <= '0;
            wb_q        <= '0;
            sb_q        <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            err_q       <= err_d;
            va_q        <= va_d;
            wa_q        <= wa_d;
            sa_q        <= sa_d;
            vb_q        <= vb_d;
            wb_q        <= wb_d;
            sb_q        <= sb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rr_ptr_o           = rr_ptr_q;
    assign err_o              = err_q;
    assign rsp_valid_o        = rsp_valid_q;
    assign rsp_rdata_packed_o = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_response_router.sv
// Bench for dmem_response_router: a 3-core/latency-3 instance checked by a response
// scoreboard, plus a 4-core/latency-1 instance for the read-race scenario.
module tb_dmem_response_router;

    localparam int LAT3 = 3;

    typedef struct {
        int          due;
        int          core;
        logic        we;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    // 3-core instance
    logic [2:0]  req_valid3, req_we3, grant3, stall3, rsp_valid3;
    logic        va3, vb3, err3;
    logic [1:0]  sa3, sb3, rr3;
    logic [31:0] mem_a3, mem_b3;
    logic [95:0] rsp_rdata3;

    // 4-core instance
    logic [3:0]   req_valid4, req_we4, grant4, stall4, rsp_valid4;
    logic         va4, vb4, err4;
    logic [1:0]   sa4, sb4, rr4;
    logic [31:0]  mem_a4, mem_b4;
    logic [127:0] rsp_rdata4;

    exp_t        sbq[$];
    logic [31:0] model[3];
    logic [2:0]  exp_mask;
    int          pop_cnt = 0;
    int          obs_cnt = 0;
    int          ovr_cyc = -1;
    logic [31:0] ovr_a = '0;

    dmem_response_router #(.NCORES(3), .DATA_WIDTH(32), .LATENCY(LAT3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid3), .req_we_i(req_we3),
        .valid_a_i(va3), .valid_b_i(vb3),
        .selector_a_i(sa3), .selector_b_i(sb3),
        .rr_ptr_o(rr3),
        .mem_rdata_a_i(mem_a3), .mem_rdata_b_i(mem_b3),
        .grant_o(grant3), .stall_o(stall3),
        .rsp_valid_o(rsp_valid3), .rsp_rdata_packed_o(rsp_rdata3),
        .err_o(err3)
    );

    dmem_response_router #(.NCORES(4), .DATA_WIDTH(32), .LATENCY(1)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid4), .req_we_i(req_we4),
        .valid_a_i(va4), .valid_b_i(vb4),
        .selector_a_i(sa4), .selector_b_i(sb4),
        .rr_ptr_o(rr4),
        .mem_rdata_a_i(mem_a4), .mem_rdata_b_i(mem_b4),
        .grant_o(grant4), .stall_o(stall4),
        .rsp_valid_o(rsp_valid4), .rsp_rdata_packed_o(rsp_rdata4),
        .err_o(err4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_a_val(input int c);
        if (c == ovr_cyc) return ovr_a;
        return 32'hA000_0000 | 32'(c);
    endfunction

    function automatic logic [31:0] mem_b_val(input int c);
        return 32'hB000_0000 | 32'(c);
    endfunction

    // Memory model for the 3-core instance: data is a known function of the cycle.
    always @(posedge clk) begin
        #1;
        mem_a3 = mem_a_val(cyc);
        mem_b3 = mem_b_val(cyc);
    end

    // Scoreboard: pop every response due this cycle and compare pulses and held data.
    always @(negedge clk) begin
        exp_mask = '0;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due == cyc) begin
                exp_mask[sbq[i].core] = 1'b1;
                if (!sbq[i].we) model[sbq[i].core] = sbq[i].data;
                sbq.delete(i);
                pop_cnt++;
            end
        end
        vectors++;
        if (rsp_valid3 !== exp_mask) begin
            miscompares++;
            $display("[TB] FAIL sb_rsp_valid cyc=%0d: got %b expected %b", cyc, rsp_valid3, exp_mask);
        end
        vectors++;
        if (rsp_rdata3 !== {model[2], model[1], model[0]}) begin
            miscompares++;
            $display("[TB] FAIL sb_rdata cyc=%0d: got %h expected %h", cyc, rsp_rdata3,
                     {model[2], model[1], model[0]});
        end
        obs_cnt += $countones(rsp_valid3);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle3();
        req_valid3 = '0; req_we3 = '0; va3 = 1'b0; vb3 = 1'b0; sa3 = '0; sb3 = '0;
    endtask

    task automatic idle4();
        req_valid4 = '0; req_we4 = '0; va4 = 1'b0; vb4 = 1'b0; sa4 = '0; sb4 = '0;
        mem_a4 = '0; mem_b4 = '0;
    endtask

    // Drive one cycle of 3-core stimulus and push the responses it should produce.
    task automatic drive3(input logic [2:0] rv, input logic [2:0] we,
                          input logic a_v, input logic [1:0] a_s,
                          input logic b_v, input logic [1:0] b_s);
        int   ai, bi;
        logic a_acc;
        exp_t e;
        ai = int'(a_s);
        bi = int'(b_s);
        req_valid3 = rv; req_we3 = we; va3 = a_v; sa3 = a_s; vb3 = b_v; sb3 = b_s;
        a_acc = 1'b0;
        if (a_v && ai < 3) begin
            if (rv[ai]) begin
                a_acc = 1'b1;
                e.due = cyc + LAT3 + 1; e.core = ai; e.we = we[ai]; e.data = mem_a_val(cyc + LAT3);
                sbq.push_back(e);
            end
        end
        if (b_v && bi < 3) begin
            if (rv[bi] && !(a_acc && ai == bi)) begin
                e.due = cyc + LAT3 + 1; e.core = bi; e.we = we[bi]; e.data = mem_b_val(cyc + LAT3);
                sbq.push_back(e);
            end
        end
    endtask

    task automatic test_reset();
        tick();
        vectors++;
        if ({rr3, err3, rr4, err4, rsp_valid4} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_in: got rr3=%0d err3=%b rr4=%0d err4=%b rsp4=%b required zeros",
                     rr3, err3, rr4, err4, rsp_valid4);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            vectors++;
            if ({rr3, err3, rr4, err4, rsp_valid4} !== '0) begin
                miscompares++;
                $display("[TB] FAIL reset_idle%0d: got rr3=%0d err3=%b rr4=%0d err4=%b rsp4=%b required zeros",
                         k, rr3, err3, rr4, err4, rsp_valid4);
            end
        end
    endtask

    task automatic test_read_race();
        tick();
        req_valid4 = 4'b1011; req_we4 = 4'b0000;
        va4 = 1'b1; sa4 = 2'd0; vb4 = 1'b1; sb4 = 2'd1;
        #1;
        vectors++;
        if (grant4 !== 4'b0011 || stall4 !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL race_grant: got grant=%b stall=%b required 0011/1000", grant4, stall4);
        end
        tick();
        idle4();
        mem_a4 = 32'hA5A5_0000; mem_b4 = 32'h0000_5A5A;
        vectors++;
        if (rr4 !== 2'd2) begin
            miscompares++;
            $display("[TB] FAIL race_rr: got %0d required 2", rr4);
        end
        tick();
        idle4();
        vectors++;
        if (rsp_valid4 !== 4'b0011 || rsp_rdata4 !== {32'h0, 32'h0, 32'h0000_5A5A, 32'hA5A5_0000}) begin
            miscompares++;
            $display("[TB] FAIL race_rsp: got valid=%b data=%h required 0011 with A5A5_0000/0000_5A5A",
                     rsp_valid4, rsp_rdata4);
        end
        tick();
        vectors++;
        if (rsp_valid4 !== 4'b0000 || rsp_rdata4[63:0] !== {32'h0000_5A5A, 32'hA5A5_0000}) begin
            miscompares++;
            $display("[TB] FAIL race_hold: got valid=%b data=%h required 0000 with data held",
                     rsp_valid4, rsp_rdata4);
        end
    endtask

    task automatic test_wrap();
        tick();
        drive3(3'b100, 3'b000, 1'b0, 2'd0, 1'b1, 2'd2);
        tick();
        idle3();
        vectors++;
        if (rr3 !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL wrap_b2: got %0d required 0", rr3);
        end
        drive3(3'b010, 3'b000, 1'b1, 2'd1, 1'b0, 2'd0);
        tick();
        idle3();
        vectors++;
        if (rr3 !== 2'd2) begin
            miscompares++;
            $display("[TB] FAIL wrap_a1: got %0d required 2", rr3);
        end
        tick();
        vectors++;
        if (rr3 !== 2'd2) begin
            miscompares++;
            $display("[TB] FAIL wrap_hold: got %0d required 2", rr3);
        end
        drive3(3'b011, 3'b000, 1'b1, 2'd1, 1'b1, 2'd0);
        tick();
        idle3();
        vectors++;
        if (rr3 !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL wrap_b_priority: got %0d required 1", rr3);
        end
        for (int k = 0; k < 6; k++) tick();
    endtask

    task automatic test_write_ack();
        int t0;
        tick();
        ovr_cyc = cyc + LAT3;
        ovr_a   = 32'h0000_1234;
        drive3(3'b100, 3'b000, 1'b1, 2'd2, 1'b0, 2'd0);
        tick();
        idle3();
        for (int k = 0; k < 5; k++) tick();
        drive3(3'b100, 3'b100, 1'b1, 2'd2, 1'b0, 2'd0);
        t0 = cyc;
        for (int k = 1; k <= 6; k++) begin
            tick();
            idle3();
            vectors++;
            if (rsp_valid3[2] !== (cyc - t0 == LAT3 + 1) || rsp_rdata3[95:64] !== 32'h0000_1234) begin
                miscompares++;
                $display("[TB] FAIL write_ack+%0d: got valid2=%b slice=%h required %b/00001234",
                         cyc - t0, rsp_valid3[2], rsp_rdata3[95:64], (cyc - t0 == LAT3 + 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        int pop0, obs0;
        pop0 = pop_cnt;
        obs0 = obs_cnt;
        for (int k = 0; k < 16; k++) begin
            tick();
            drive3(3'b111, 3'(k % 8), 1'b1, 2'(k % 3), 1'b1, 2'((k + 1) % 3));
        end
        tick();
        idle3();
        for (int k = 0; k < LAT3 + 3; k++) tick();
        vectors++;
        if (obs_cnt - obs0 !== 32 || pop_cnt - pop0 !== 32) begin
            miscompares++;
            $display("[TB] FAIL stream_count: got observed=%0d popped=%0d required 32",
                     obs_cnt - obs0, pop_cnt - pop0);
        end
    endtask

    task automatic test_violation();
        tick();
        drive3(3'b010, 3'b000, 1'b1, 2'd1, 1'b1, 2'd1);
        tick();
        idle3();
        vectors++;
        if (err3 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL collide_err: got %b required 1", err3);
        end
        for (int k = 0; k < LAT3 + 3; k++) tick();
        vectors++;
        if (err3 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL collide_sticky: got %b required 1", err3);
        end
    endtask

    task automatic test_midflight_reset();
        tick();
        drive3(3'b011, 3'b000, 1'b1, 2'd0, 1'b1, 2'd1);
        tick();
        idle3();
        rst_n = 1'b0;
        sbq.delete();
        for (int i = 0; i < 3; i++) model[i] = '0;
        #1;
        vectors++;
        if (rr3 !== 2'd0 || err3 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midflight_reset: got rr=%0d err=%b required 0/0", rr3, err3);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < LAT3 + 4; k++) tick();
    endtask

    task automatic test_bad_selector();
        tick();
        drive3(3'b111, 3'b000, 1'b1, 2'd3, 1'b1, 2'd2);
        #1;
        vectors++;
        if (grant3 !== 3'b100 || stall3 !== 3'b011) begin
            miscompares++;
            $display("[TB] FAIL badsel_grant: got grant=%b stall=%b required 100/011", grant3, stall3);
        end
        tick();
        idle3();
        vectors++;
        if (err3 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL badsel_err: got %b required 1", err3);
        end
        for (int k = 0; k < LAT3 + 3; k++) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) model[i] = '0;
        mem_a3 = '0;
        mem_b3 = '0;
        idle3();
        idle4();
        test_reset();
        test_read_race();
        test_wrap();
        test_write_ack();
        test_back_to_back();
        test_violation();
        test_midflight_reset();
        test_bad_selector();
        vectors++;
        if (sbq.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending responses required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_response_router.md
Name: dmem_response_router

Overview:
- Return-path and bookkeeping companion to the dual-issue data-memory arbiter.
- Each cycle it:
  - takes the arbiter's port-A/port-B grant decision;
  - tells every core whether its request was accepted or must stall;
  - advances the round-robin pointer fed back to the arbiter;
  - tracks in-flight accesses through the fixed-latency dual-port memory;
  - routes read data and write acknowledgements back to the originating core.
- Sits between the arbiter/memory pair and the per-core load/store units.

Parameters:
- NCORES, `NCORES, number of requesting cores (≥2, need not be a power of two).
- DATA_WIDTH, 32, memory data width.
- LATENCY, 1, cycles from issue to valid mem_rdata_*_i (≥1).

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- req_valid_i  input  NCORES  per-core request pending this cycle.
- req_we_i  input  NCORES  per-core request is a write.
- valid_a_i  input  1  arbiter grant on port A.
- valid_b_i  input  1  arbiter grant on port B.
- selector_a_i  input  $clog2(NCORES)  core granted port A.
- selector_b_i  input  $clog2(NCORES)  core granted port B.
- rr_ptr_o  output  $clog2(NCORES)  round-robin pointer to arbiter.
- mem_rdata_a_i  input  DATA_WIDTH  port A read data, valid LATENCY cycles after issue.
- mem_rdata_b_i  input  DATA_WIDTH  port B read data, valid LATENCY cycles after issue.
- grant_o  output  NCORES  combinational; core's request accepted this cycle.
- stall_o  output  NCORES  combinational; req_valid_i & ~grant_o.
- rsp_valid_o  output  NCORES  registered one-cycle response pulse per core.
- rsp_rdata_packed_o  output  NCORES*DATA_WIDTH  registered per-core read data; core i at bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
- err_o  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst_ni low, async) forces:
  - rr_ptr_o=0, rsp_valid_o=0, rsp_rdata_packed_o=0, err_o=0;
  - all pipeline stage valids=0.
- Deassertion has no side effects. In-flight accesses at reset are dropped and never answered.
- grant_o (combinational):
  - bit selector_a_i set if valid_a_i;
  - bit selector_b_i set if valid_b_i;
  - both bits masked by req_valid_i;
  - no other bits set.
- stall_o = req_valid_i & ~grant_o (combinational).
- Round-robin pointer update:
  - if valid_b_i: next = selector_b_i+1;
  - else if valid_a_i: next = selector_a_i+1;
  - else: hold.
  - Increment wraps: NCORES-1 → 0, explicit compare, no power-of-two masking.
- Issue pipeline:
  - LATENCY-stage shift register, one entry per cycle: {va, sa, wa, vb, sb, wb}.
  - Stage 0 captures valid_x_i & req_valid_i[selector_x_i], selector_x_i, req_we_i[selector_x_i].
  - Advances every cycle; no backpressure (memory has fixed latency).
- Response stage, registered. For an access issued in cycle T:
  - In cycle T+LATENCY the tail stage entry pairs with mem_rdata_*_i.
  - rsp_valid_o[s] pulses high in cycle T+LATENCY+1.
  - Read: core s's rsp_rdata slice loads the corresponding port's data.
  - Write: rsp_valid_o[s] pulses; rdata slice holds its previous value.
- rsp_rdata slices hold until that core's next read response.
- rsp_valid_o bits not addressed in a cycle are 0.
- Simultaneous A and B responses to different cores: both pulse in the same cycle.
- Violation — va & vb with sa==sb in any captured entry:
  - port A's response wins;
  - port B entry discarded;
  - err_o set, stays 1 until reset.
- Violation — selector ≥ NCORES with its valid asserted:
  - grant suppressed, entry not captured;
  - err_o set.
- Back-to-back issues every cycle on both ports sustain full throughput: 2 responses/cycle.

Test Plan:
- Reset, then idle 5 cycles → rr_ptr_o=0, rsp_valid_o=0, err_o=0 throughout.
- Read race, NCORES=4, LATENCY=1:
  - stimulus: req_valid=4'b1011, valid_a=1 sel_a=0, valid_b=1 sel_b=1, all reads; next cycle mem_rdata_a=32'hA5A5_0000, mem_rdata_b=32'h0000_5A5A;
  - response: grant_o=4'b0011, stall_o=4'b1000;
  - rr_ptr_o=2 next cycle;
  - two cycles after issue: rsp_valid_o=4'b0011, core0 slice=A5A5_0000, core1 slice=0000_5A5A.
- Wrap, NCORES=3:
  - grant B to core 2 → rr_ptr_o=0;
  - grant only A to core 1 (valid_b=0) → rr_ptr_o=2.
- Write ack, LATENCY=3: core 2 write on port A, core 2 rdata slice preloaded 32'h1234 → rsp_valid_o[2] pulses exactly 4 cycles after issue; slice stays 32'h1234.
- Streaming: both ports issue every cycle for 16 cycles, rotating cores → 32 responses, each arriving LATENCY+1 cycles after issue, none lost or duplicated.
- Violation: valid_a=valid_b=1, sel_a=sel_b=1 → only port A data delivered to core 1; err_o=1 and sticky.
- Mid-flight reset: reset asserted with 2 accesses in flight → no rsp_valid_o pulse after reset.
